// File: rtl/cycle_timer.sv
// cycle_timer: prescaled cycle counter with compare-match interrupt,
// accessed through a single-cycle register bus with registered reads.
module cycle_timer #(
  parameter int COUNT_WIDTH    = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2:0]             addr,
  input  logic                   wen,
  input  logic                   ren,
  input  logic [COUNT_WIDTH-1:0] wdata,
  output logic [COUNT_WIDTH-1:0] rdata,
  output logic                   rvalid,
  output logic                   irq
);

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_PRESCALE = 3'd1;
  localparam logic [2:0] ADDR_COUNT    = 3'd2;
  localparam logic [2:0] ADDR_COMPARE  = 3'd3;
  localparam logic [2:0] ADDR_STATUS   = 3'd4;

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_PERIOD = 1;
  localparam int CTRL_IRQEN  = 2;

  logic [2:0]                ctrl_q, ctrl_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [COUNT_WIDTH-1:0]    count_q, count_d;
  logic [COUNT_WIDTH-1:0]    compare_q, compare_d;
  logic                      pending_q, pending_d;
  logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [COUNT_WIDTH-1:0]    rdata_q, rdata_d;
  logic                      rvalid_q, rvalid_d;

  logic                   wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
  logic                   tick, match;
  logic [COUNT_WIDTH-1:0] read_val;

  // Write decode, prescaler tick and compare match.
  always_comb begin
    wr_ctrl     = wen && (addr == ADDR_CTRL);
    wr_prescale = wen && (addr == ADDR_PRESCALE);
    wr_count    = wen && (addr == ADDR_COUNT);
    wr_compare  = wen && (addr == ADDR_COMPARE);
    wr_status   = wen && (addr == ADDR_STATUS);
    // A CTRL/PRESCALE write restarts the prescaler, so it can never tick then.
    tick  = ctrl_q[CTRL_EN] && !wr_ctrl && !wr_prescale && (pcnt_q == prescale_q);
    match = (count_q == compare_q);
  end

  // Next-state for the timer registers; CPU writes take priority over tick effects.
  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    count_d    = count_q;
    compare_d  = compare_q;
    pending_d  = pending_q;
    pcnt_d     = pcnt_q;

    // Prescaler: held at 0 while disabled, wraps to 0 on the tick cycle.
    if (wr_ctrl || wr_prescale || !ctrl_q[CTRL_EN] || (pcnt_q == prescale_q)) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PRESCALE_WIDTH'(1);
    end

    if (tick) begin
      if (match) begin
        if (ctrl_q[CTRL_PERIOD]) begin
          count_d = '0;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
        end
      end else begin
        count_d = count_q + COUNT_WIDTH'(1);
      end
    end

    // Write-1-to-clear, but a same-cycle match keeps pending set.
    if (wr_status && wdata[0]) pending_d = 1'b0;
    if (tick && match)         pending_d = 1'b1;

    if (wr_ctrl)     ctrl_d     = wdata[2:0];
    if (wr_prescale) prescale_d = wdata[PRESCALE_WIDTH-1:0];
    if (wr_count)    count_d    = wdata;
    if (wr_compare)  compare_d  = wdata;
  end

  // Read mux; rdata holds its last value between reads.
  always_comb begin
    case (addr)
      ADDR_CTRL:     read_val = COUNT_WIDTH'(ctrl_q);
      ADDR_PRESCALE: read_val = COUNT_WIDTH'(prescale_q);
      ADDR_COUNT:    read_val = count_q;
      ADDR_COMPARE:  read_val = compare_q;
      ADDR_STATUS:   read_val = COUNT_WIDTH'(pending_q);
      default:       read_val = '0;
    endcase
    rdata_d  = ren ? read_val : rdata_q;
    rvalid_d = ren;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      count_q    <= '0;
      compare_q  <= '1;
      pending_q  <= 1'b0;
      pcnt_q     <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      pending_q  <= pending_d;
      pcnt_q     <= pcnt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign irq    = pending_q & ctrl_q[CTRL_IRQEN];

endmodule

// File: tb/tb_cycle_timer.sv
// Directed bench for cycle_timer: register-access vector table followed by
// hand-timed sequences for prescaling, one-shot, wrap, collisions and reset.
module tb_cycle_timer;

  logic        clk;
  logic        rst;
  logic [2:0]  addr;
  logic        wen;
  logic        ren;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        irq;

  int checks;
  int errors;

  cycle_timer #(.COUNT_WIDTH(32), .PRESCALE_WIDTH(16)) dut (
    .clock  (clk),
    .reset  (rst),
    .addr   (addr),
    .wen    (wen),
    .ren    (ren),
    .wdata  (wdata),
    .rdata  (rdata),
    .rvalid (rvalid),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic        ren;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_rvalid;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    wen = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wen = 1'b0;
    $display("write addr=%0d data=%h", a, d);
  endtask

  task automatic read_reg(input string name, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    ren = 1'b1; addr = a;
    @(negedge clk);
    ren = 1'b0;
    $display("read  addr=%0d data=%h rvalid=%0b", a, rdata, rvalid);
    check({name, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    check(name, rdata, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; wen = 1'b0; ren = 1'b0; addr = 3'd0; wdata = 32'd0;

    //                wen   ren   addr  wdata         chk   exp           rv
    vecs[0]  = '{1'b0, 1'b1, 3'd0, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[1]  = '{1'b0, 1'b1, 3'd1, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[2]  = '{1'b0, 1'b1, 3'd2, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[3]  = '{1'b0, 1'b1, 3'd3, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 3'd4, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[5]  = '{1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'd0, 32'hFFFFFFF8, 1'b0, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 1'b1, 3'd0, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[8]  = '{1'b1, 1'b1, 3'd1, 32'h00001234, 1'b1, 32'h0,        1'b1};
    vecs[9]  = '{1'b0, 1'b1, 3'd1, 32'h0,        1'b1, 32'h00001234, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 3'd5, 32'h0000DEAD, 1'b0, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 1'b1, 3'd5, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 1'b1, 3'd7, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[13] = '{1'b1, 1'b0, 3'd3, 32'hA5A50001, 1'b0, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 1'b1, 3'd3, 32'h0,        1'b1, 32'hA5A50001, 1'b1};
    vecs[15] = '{1'b1, 1'b1, 3'd4, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[16] = '{1'b1, 1'b0, 3'd2, 32'h00000007, 1'b0, 32'h0,        1'b0};
    vecs[17] = '{1'b0, 1'b1, 3'd2, 32'h0,        1'b1, 32'h00000007, 1'b1};

    // Reset state on the outputs.
    repeat (3) @(negedge clk);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_rvalid", {31'd0, rvalid}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    rst = 1'b0;

    // Register-access table, one bus cycle per vector.
    for (int i = 0; i < 18; i++) begin
      wen = vecs[i].wen; ren = vecs[i].ren; addr = vecs[i].addr; wdata = vecs[i].wdata;
      @(negedge clk);
      $display("vec %0d wen=%0b ren=%0b addr=%0d wdata=%h rdata=%h rvalid=%0b",
               i, vecs[i].wen, vecs[i].ren, vecs[i].addr, vecs[i].wdata, rdata, rvalid);
      check($sformatf("vec%0d_rvalid", i), {31'd0, rvalid}, {31'd0, vecs[i].exp_rvalid});
      if (vecs[i].chk_data) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_data);
    end
    wen = 1'b0; ren = 1'b0;

    // Periodic: PRESCALE=3, COMPARE=2 -> COUNT steps every 4 cycles, match at edge 12.
    write_reg(3'd2, 32'd0);
    write_reg(3'd1, 32'd3);
    write_reg(3'd3, 32'd2);
    write_reg(3'd0, 32'd7);
    ren = 1'b1; addr = 3'd2;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      $display("periodic k=%0d count=%h irq=%0b", k, rdata, irq);
      check($sformatf("per_count_k%0d", k), rdata, 32'((k - 1) / 4 % 3));
      check($sformatf("per_irq_k%0d", k), {31'd0, irq}, {31'd0, (k >= 12)});
      check($sformatf("per_rvalid_k%0d", k), {31'd0, rvalid}, 32'd1);
    end
    ren = 1'b0;
    write_reg(3'd4, 32'd1);
    check("per_irq_cleared", {31'd0, irq}, 32'd0);
    write_reg(3'd0, 32'd0);

    // One-shot: PRESCALE=0, COMPARE=5, CTRL=enable|irq_en.
    write_reg(3'd2, 32'd0);
    write_reg(3'd1, 32'd0);
    write_reg(3'd3, 32'd5);
    write_reg(3'd4, 32'd1);
    write_reg(3'd0, 32'd5);
    ren = 1'b1; addr = 3'd4;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      $display("oneshot k=%0d status=%h", k, rdata);
      check($sformatf("os_pending_k%0d", k), rdata, {31'd0, (k >= 7)});
    end
    ren = 1'b0;
    repeat (5) @(negedge clk);
    read_reg("os_ctrl", 3'd0, 32'd4);
    read_reg("os_count", 3'd2, 32'd5);
    repeat (5) @(negedge clk);
    read_reg("os_count_held", 3'd2, 32'd5);
    read_reg("os_status", 3'd4, 32'd1);
    check("os_irq", {31'd0, irq}, 32'd1);

    // Wrap: COUNT runs through all-ones to 0 with no flag, matches at 0x10.
    write_reg(3'd4, 32'd1);
    write_reg(3'd2, 32'hFFFFFFFE);
    write_reg(3'd3, 32'h10);
    write_reg(3'd0, 32'd5);
    ren = 1'b1; addr = 3'd2;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      $display("wrap k=%0d count=%h irq=%0b", k, rdata, irq);
      check($sformatf("wrap_count_k%0d", k), rdata,
            (k - 1 <= 18) ? 32'hFFFFFFFE + 32'(k - 1) : 32'h10);
      check($sformatf("wrap_irq_k%0d", k), {31'd0, irq}, {31'd0, (k >= 19)});
    end
    ren = 1'b0;

    // Collision: STATUS clear on the match edge leaves pending set.
    write_reg(3'd4, 32'd1);
    write_reg(3'd2, 32'd0);
    write_reg(3'd3, 32'd3);
    write_reg(3'd0, 32'd7);
    repeat (2) @(negedge clk);
    write_reg(3'd4, 32'd1);
    check("coll_clear_vs_match_irq", {31'd0, irq}, 32'd1);
    write_reg(3'd0, 32'd0);

    // Collision: COUNT write on a tick edge wins over the increment.
    write_reg(3'd4, 32'd1);
    write_reg(3'd3, 32'hFFFFFFFF);
    write_reg(3'd2, 32'd0);
    write_reg(3'd0, 32'd1);
    write_reg(3'd2, 32'h100);
    ren = 1'b1; addr = 3'd2;
    @(negedge clk);
    $display("coll count=%h", rdata);
    check("coll_count_write", rdata, 32'h100);
    @(negedge clk);
    $display("coll count=%h", rdata);
    check("coll_count_next", rdata, 32'h101);
    ren = 1'b0;
    write_reg(3'd0, 32'd0);

    // Asynchronous reset with irq high and COUNT=7 mid-prescale.
    write_reg(3'd4, 32'd1);
    write_reg(3'd2, 32'd0);
    write_reg(3'd3, 32'd0);
    write_reg(3'd1, 32'd3);
    write_reg(3'd0, 32'd7);
    repeat (4) @(negedge clk);
    check("rst_pre_irq", {31'd0, irq}, 32'd1);
    write_reg(3'd3, 32'hFFFFFFFF);
    write_reg(3'd2, 32'd7);
    @(negedge clk);
    ren = 1'b1; addr = 3'd2;
    @(posedge clk);
    #2;
    check("rst_pre_rvalid", {31'd0, rvalid}, 32'd1);
    check("rst_pre_count", rdata, 32'd7);
    rst = 1'b1;
    #1;
    $display("async reset irq=%0b rvalid=%0b rdata=%h", irq, rvalid, rdata);
    check("rst_async_irq", {31'd0, irq}, 32'd0);
    check("rst_async_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_async_rdata", rdata, 32'd0);
    @(negedge clk);
    ren = 1'b0;
    rst = 1'b0;
    read_reg("post_rst_count", 3'd2, 32'd0);
    read_reg("post_rst_ctrl", 3'd0, 32'd0);
    read_reg("post_rst_compare", 3'd3, 32'hFFFFFFFF);
    read_reg("post_rst_prescale", 3'd1, 32'd0);
    read_reg("post_rst_status", 3'd4, 32'd0);

    // Restart after reset: PRESCALE=0, COMPARE=2, periodic.
    write_reg(3'd3, 32'd2);
    write_reg(3'd0, 32'd3);
    ren = 1'b1; addr = 3'd2;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      $display("restart k=%0d count=%h", k, rdata);
      check($sformatf("restart_count_k%0d", k), rdata, 32'((k - 1) % 3));
    end
    ren = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
